umem_arbiter: RTL and testbench

// - Shares one single-ported unified instruction/data memory between the IF stage (fetch) and the MEM stage (load/store).
// - Registered arbiter/sequencer: grants one requester, drives the memory, waits for mem_ready, returns registered data with a 1-cycle ack.
// - Requesters stall the pipeline while req=1 and ack=0.
// - Data port has priority; a streak counter guarantees fetch progress.

---
 rtl/umem_arbiter.sv | 123 ++++++++++++
 tb/tb_umem_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/umem_arbiter.sv
// Unified instruction/data memory arbiter.
// Shares one single-ported memory between the fetch (IF) and load/store (DM)
// requesters. Data accesses win by default; a streak counter forces a fetch
// grant after DM_STREAK_MAX consecutive data grants while a fetch is waiting.
module umem_arbiter #(
    parameter int AW            = 32,
    parameter int DW            = 32,
    parameter int DM_STREAK_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    input  logic [3:0]    dm_amp,
    output logic          dm_ack,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [3:0]    mem_be,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdata
);

    localparam int SW = $clog2(DM_STREAK_MAX + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY_IF = 2'd1;
    localparam logic [1:0] ST_BUSY_DM = 2'd2;

    logic [1:0]    state;
    logic [SW-1:0] streak;
    logic          streak_full;
    logic          arb_open;
    logic          if_elig;
    logic          dm_elig;
    logic          grant_if;
    logic          grant_dm;

    // Arbitration decision for the IDLE state.
    // No grant is made while any ack pulse is out: the acked requester is
    // blocked from double-issuing, and holding the other one back for that
    // cycle lets the acked requester compete again with its next request,
    // which keeps the DM/IF streak pattern intact under contention.
    always_comb begin
        streak_full = (streak == SW'(DM_STREAK_MAX));
        arb_open    = !if_ack && !dm_ack;
        if_elig     = if_req && arb_open;
        dm_elig     = dm_req && arb_open;
        grant_dm    = dm_elig && !(if_elig && streak_full);
        grant_if    = if_elig && !grant_dm;
    end

    // Sequencer: grant, drive memory until mem_ready, return registered data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            streak    <= '0;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else begin
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_dm) begin
                        state     <= ST_BUSY_DM;
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        mem_be    <= dm_we ? dm_amp : 4'hF;
                        if (if_elig)
                            streak <= streak_full ? streak : streak + 1'b1;
                        else
                            streak <= '0;
                    end else if (grant_if) begin
                        state    <= ST_BUSY_IF;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= if_addr;
                        mem_be   <= 4'hF;
                        streak   <= '0;
                    end
                end
                ST_BUSY_IF: begin
                    if (mem_ready) begin
                        state    <= ST_IDLE;
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        if_ack   <= 1'b1;
                        if_rdata <= mem_rdata;
                    end
                end
                ST_BUSY_DM: begin
                    if (mem_ready) begin
                        state    <= ST_IDLE;
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        dm_ack   <= 1'b1;
                        dm_rdata <= mem_rdata;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_umem_arbiter.sv
// Self-checking bench for umem_arbiter: cycle-by-cycle vector table followed
// by hand-written contention, mid-access reset and ack-masking sequences.
module tb_umem_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_amp;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int compared = 0;
    int failed   = 0;
    int cycle    = 0;

    umem_arbiter #(
        .AW(32),
        .DW(32),
        .DM_STREAK_MAX(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .if_req(if_req),
        .if_addr(if_addr),
        .if_ack(if_ack),
        .if_rdata(if_rdata),
        .dm_req(dm_req),
        .dm_we(dm_we),
        .dm_addr(dm_addr),
        .dm_wdata(dm_wdata),
        .dm_amp(dm_amp),
        .dm_ack(dm_ack),
        .dm_rdata(dm_rdata),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_be(mem_be),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst_n;
        logic        if_req;
        logic [31:0] if_addr;
        logic        dm_req;
        logic        dm_we;
        logic [31:0] dm_addr;
        logic [31:0] dm_wdata;
        logic [3:0]  dm_amp;
        logic        mem_ready;
        logic [31:0] mem_rdata;
        logic        e_mem_req;
        logic        e_mem_we;
        logic [31:0] e_mem_addr;
        logic [31:0] e_mem_wdata;
        logic [3:0]  e_mem_be;
        logic        e_if_ack;
        logic        e_dm_ack;
        logic [31:0] e_if_rdata;
        logic [31:0] e_dm_rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic step();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, cycle, act, exp);
        end
    endtask

    task automatic idle_inputs();
        if_req    = 1'b0;
        if_addr   = '0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        dm_amp    = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    // Wait (bounded) for a grant to appear on mem_req.
    task automatic wait_grant(input string name, output bit ok);
        int n;
        n  = 0;
        ok = 1'b1;
        while (mem_req !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        if (mem_req !== 1'b1) begin
            ok = 1'b0;
            chk({name, "_timeout"}, {31'd0, mem_req}, 32'd1);
        end
    endtask

    initial begin
        bit ok;
        reset = 1'b0;
        idle_inputs();

        //            name          rst ifr ifa       dmr dwe dma       dmw          amp   rdy mrd          | mreq mwe maddr     mwdata       mbe   ia  da  ird          drd
        vecs.push_back('{"rst0",     0, 1, 32'h100,  0, 0, 32'h0,    32'h0,       4'h0, 0, 32'h0,        0, 0, 32'h0,    32'h0,       4'h0, 0, 0, 32'h0,       32'h0});
        vecs.push_back('{"rst1",     0, 1, 32'h100,  0, 0, 32'h0,    32'h0,       4'h0, 0, 32'h0,        0, 0, 32'h0,    32'h0,       4'h0, 0, 0, 32'h0,       32'h0});
        vecs.push_back('{"if_grant", 1, 1, 32'h100,  0, 0, 32'h0,    32'h0,       4'h0, 0, 32'h0,        1, 0, 32'h100,  32'h0,       4'hF, 0, 0, 32'h0,       32'h0});
        vecs.push_back('{"if_wait",  1, 1, 32'h100,  0, 0, 32'h0,    32'h0,       4'h0, 0, 32'h0,        1, 0, 32'h100,  32'h0,       4'hF, 0, 0, 32'h0,       32'h0});
        vecs.push_back('{"if_done",  1, 1, 32'h100,  0, 0, 32'h0,    32'h0,       4'h0, 1, 32'h00500093, 0, 0, 32'h100,  32'h0,       4'hF, 1, 0, 32'h00500093, 32'h0});
        vecs.push_back('{"if_post",  1, 0, 32'h100,  0, 0, 32'h0,    32'h0,       4'h0, 0, 32'h0,        0, 0, 32'h100,  32'h0,       4'hF, 0, 0, 32'h00500093, 32'h0});
        vecs.push_back('{"st_grant", 1, 0, 32'h0,    1, 1, 32'h2003, 32'hAB000000, 4'h8, 0, 32'h0,        1, 1, 32'h2003, 32'hAB000000, 4'h8, 0, 0, 32'h00500093, 32'h0});
        vecs.push_back('{"st_done",  1, 0, 32'h0,    1, 1, 32'h2003, 32'hAB000000, 4'h8, 1, 32'hDEADBEEF, 0, 0, 32'h2003, 32'hAB000000, 4'h8, 0, 1, 32'h00500093, 32'hDEADBEEF});
        vecs.push_back('{"idle_rdy", 1, 0, 32'h0,    0, 0, 32'h0,    32'h0,       4'h0, 1, 32'h12345678, 0, 0, 32'h2003, 32'hAB000000, 4'h8, 0, 0, 32'h00500093, 32'hDEADBEEF});
        vecs.push_back('{"ld_grant", 1, 0, 32'h0,    1, 0, 32'h3000, 32'h55,      4'h1, 0, 32'h0,        1, 0, 32'h3000, 32'h55,      4'hF, 0, 0, 32'h00500093, 32'hDEADBEEF});
        vecs.push_back('{"ld_done",  1, 0, 32'h0,    1, 0, 32'h3000, 32'h55,      4'h1, 1, 32'hCAFEF00D, 0, 0, 32'h3000, 32'h55,      4'hF, 0, 1, 32'h00500093, 32'hCAFEF00D});
        vecs.push_back('{"ld_post",  1, 0, 32'h0,    0, 0, 32'h0,    32'h0,       4'h0, 0, 32'h0,        0, 0, 32'h3000, 32'h55,      4'hF, 0, 0, 32'h00500093, 32'hCAFEF00D});

        foreach (vecs[i]) begin
            reset     = vecs[i].rst_n;
            if_req    = vecs[i].if_req;
            if_addr   = vecs[i].if_addr;
            dm_req    = vecs[i].dm_req;
            dm_we     = vecs[i].dm_we;
            dm_addr   = vecs[i].dm_addr;
            dm_wdata  = vecs[i].dm_wdata;
            dm_amp    = vecs[i].dm_amp;
            mem_ready = vecs[i].mem_ready;
            mem_rdata = vecs[i].mem_rdata;
            step();
            chk({vecs[i].name, ".mem_req"},   {31'd0, mem_req},  {31'd0, vecs[i].e_mem_req});
            chk({vecs[i].name, ".mem_we"},    {31'd0, mem_we},   {31'd0, vecs[i].e_mem_we});
            chk({vecs[i].name, ".mem_addr"},  mem_addr,          vecs[i].e_mem_addr);
            chk({vecs[i].name, ".mem_wdata"}, mem_wdata,         vecs[i].e_mem_wdata);
            chk({vecs[i].name, ".mem_be"},    {28'd0, mem_be},   {28'd0, vecs[i].e_mem_be});
            chk({vecs[i].name, ".if_ack"},    {31'd0, if_ack},   {31'd0, vecs[i].e_if_ack});
            chk({vecs[i].name, ".dm_ack"},    {31'd0, dm_ack},   {31'd0, vecs[i].e_dm_ack});
            chk({vecs[i].name, ".if_rdata"},  if_rdata,          vecs[i].e_if_rdata);
            chk({vecs[i].name, ".dm_rdata"},  dm_rdata,          vecs[i].e_dm_rdata);
        end

        // Contention: both requesters held; expect DM x4 then IF, repeating.
        do_reset();
        if_req  = 1'b1;
        if_addr = 32'h0000_0100;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h0000_8000;
        for (int n = 0; n < 12; n++) begin
            wait_grant($sformatf("cont%0d", n), ok);
            if (!ok) break;
            chk($sformatf("cont%0d.grant_addr", n), mem_addr,
                (n % 5 == 4) ? 32'h0000_0100 : 32'h0000_8000);
            mem_ready = 1'b1;
            mem_rdata = 32'h1000 + n;
            step();
            mem_ready = 1'b0;
            chk($sformatf("cont%0d.ack", n), {30'd0, if_ack, dm_ack},
                (n % 5 == 4) ? 32'd2 : 32'd1);
        end

        // Reset in the middle of a store: access abandoned, no ack follows.
        do_reset();
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 32'h0000_2000;
        dm_wdata = 32'h1122_3344;
        dm_amp   = 4'h3;
        step();
        chk("mrst.grant", {31'd0, mem_req}, 32'd1);
        chk("mrst.be", {28'd0, mem_be}, 32'h3);
        step();
        reset = 1'b0;
        step();
        chk("mrst.mem_req", {31'd0, mem_req}, 32'd0);
        chk("mrst.mem_we", {31'd0, mem_we}, 32'd0);
        reset     = 1'b1;
        dm_req    = 1'b0;
        mem_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            step();
            chk($sformatf("mrst.no_ack%0d", n), {30'd0, if_ack, dm_ack}, 32'd0);
            chk($sformatf("mrst.idle%0d", n), {31'd0, mem_req}, 32'd0);
        end
        mem_ready = 1'b0;

        // Ack masking: DM held, ready in first busy cycle -> exactly 3 cycles per access.
        do_reset();
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h0000_0040;
        wait_grant("mask", ok);
        if (ok) begin
            for (int n = 0; n < 3; n++) begin
                mem_ready = 1'b1;
                mem_rdata = 32'hA000 + n;
                step();
                mem_ready = 1'b0;
                chk($sformatf("mask%0d.ack", n), {31'd0, dm_ack}, 32'd1);
                chk($sformatf("mask%0d.rdata", n), dm_rdata, 32'hA000 + n);
                step();
                chk($sformatf("mask%0d.no_dup", n), {31'd0, mem_req}, 32'd0);
                chk($sformatf("mask%0d.ack_clr", n), {31'd0, dm_ack}, 32'd0);
                step();
                chk($sformatf("mask%0d.regrant", n), {31'd0, mem_req}, 32'd1);
            end
        end
        dm_req = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

    // Global watchdog so the run can never hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

endmodule
